wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter ADDR_W, default 5, register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  producer offers a writeback result.
REQ-007 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-008 SHALL have port in_addr  input  ADDR_W  destination register.
REQ-009 SHALL have port in_data  input  DATA_W  result value.
REQ-010 SHALL have port wr_hold  input  1  pauses draining to the register file.
REQ-011 SHALL have port wr_en  output  1  register-file write strobe, registered.
REQ-012 SHALL have port wr_addr  output  ADDR_W  register-file write address (rgAddW side), registered.
REQ-013 SHALL have port wr_data  output  DATA_W  register-file write data (dataW side), registered.
REQ-014 SHALL have port fwd_addr  input  ADDR_W  operand address for bypass lookup.
REQ-015 SHALL have port fwd_hit  output  1  pending write to fwd_addr exists.
REQ-016 SHALL have port fwd_data  output  DATA_W  youngest pending value for fwd_addr.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-018 SHALL transfer an entry on a posedge where in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready = (count < DEPTH), registered-state only; no combinational dependence on same-cycle pop.
REQ-020 SHALL accept but discard transfers with in_addr == 0 (no slot consumed, no wr_en, no forward).
REQ-021 SHALL store entries FIFO-ordered in a circular buffer; read/write pointers wrap modulo DEPTH.
REQ-022 SHALL pop the head on a posedge where count > 0 and wr_hold == 0, loading wr_addr/wr_data and setting wr_en = 1 for the following cycle.
REQ-023 SHALL set wr_en = 0 on any posedge with no pop; wr_addr/wr_data hold their last values.
REQ-024 SHALL give minimum latency of one cycle: entry accepted at edge N yields wr_en high after edge N+1.
REQ-025 SHALL on simultaneous push and pop update count by net zero; pushing into a full queue is impossible because in_ready = 0.
REQ-026 SHALL compute fwd_hit/fwd_data combinationally over all valid queue entries plus the output register while wr_en = 1; youngest match wins; output register is oldest.
REQ-027 SHALL return fwd_hit = 0 and fwd_data = 0 when fwd_addr == 0 or no match.
REQ-028 SHALL not include the current-cycle in_* transfer in the forward search.

Reset
REQ-029 SHALL on rst = 1 immediately clear count, pointers, wr_en, wr_addr, wr_data to 0; in_ready = 1 and fwd_hit = 0.
REQ-030 SHALL discard all pending entries when reset asserts mid-operation; no wr_en pulse during or after reset until a new transfer.

Configuration
REQ-031 SHALL, when macro WBQ_COALESCE_EN is defined, overwrite in place the data of the youngest queued entry whose address equals in_addr instead of allocating a slot (count unchanged, accepted even when full if a match exists).
REQ-032 SHALL, with WBQ_COALESCE_EN, still allocate a new slot if the only match is the head being popped that same edge.
REQ-033 SHALL, without WBQ_COALESCE_EN, always allocate one slot per nonzero-address transfer; in_ready per REQ-019.

Verification
REQ-034 SHALL cover: push (addr 3, 0x11) with wr_hold = 0 -> wr_en = 1, wr_addr = 3, wr_data = 0x11 one cycle after acceptance, count back to 0.
REQ-035 SHALL cover: wr_hold = 1, push 4 entries addr 1..4 -> count = 4, in_ready = 0; release hold -> writes 1,2,3,4 on 4 consecutive cycles.
REQ-036 SHALL cover: push (5,0xA) then (5,0xB), fwd_addr = 5 with hold -> fwd_hit = 1, fwd_data = 0xB (coalesce on: count = 1; off: count = 2).
REQ-037 SHALL cover: push (0, 0xFFFF) -> no count change, no wr_en, fwd_addr = 0 gives fwd_hit = 0.
REQ-038 SHALL cover: 3 entries queued, assert rst between edges -> count = 0, wr_en = 0 immediately, no writes after release.
REQ-039 SHALL cover: steady push every cycle with hold = 0 over 10 cycles -> count stays 1, pointers wrap, wr_addr sequence matches input order.

Source files
------------

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of pending register writebacks with a registered
// register-file write port and a youngest-wins operand bypass lookup.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - producer handshake; in_addr/in_data carry the result
//   wr_hold             - stalls draining into the register file
//   wr_en/wr_addr/wr_data - registered register-file write port
//   fwd_addr -> fwd_hit/fwd_data - bypass lookup over pending writes
//   count               - number of queued entries
//
// Option: define WBQ_COALESCE_EN to merge a write into the youngest queued
// entry that targets the same register instead of allocating a new slot.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      wr_hold,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic          full;
    logic          pop;
    logic          accept;
    logic          alloc;
    logic [PW-1:0] widx;
    logic [PW-1:0] f_idx;

    assign full   = (count == FULL);
    assign pop    = (count != '0) && !wr_hold;
    assign accept = in_valid && in_ready && (in_addr != '0);

`ifdef WBQ_COALESCE_EN
    logic          tail_hit;
    logic [PW-1:0] tail_idx;
    logic [PW-1:0] c_idx;
    logic          head_hit;
    logic          coal_hit;

    // Youngest match among non-head entries. The head is handled apart
    // because it may be leaving the queue on this very edge.
    always_comb begin
        tail_hit = 1'b0;
        tail_idx = rd_ptr;
        c_idx    = rd_ptr;
        for (int i = 1; i < DEPTH; i++) begin
            c_idx = rd_ptr + PW'(i);
            if (CW'(i) < count && addr_q[c_idx] == in_addr) begin
                tail_hit = 1'b1;
                tail_idx = c_idx;
            end
        end
    end

    assign head_hit = (count != '0) && (addr_q[rd_ptr] == in_addr);
    assign coal_hit = tail_hit || (head_hit && !pop);

    // A non-head match can always be merged, even when full; this keeps
    // in_ready independent of whether the head pops this cycle.
    assign in_ready = !full || tail_hit;
    assign alloc    = accept && !coal_hit;
    assign widx     = !coal_hit ? wr_ptr :
                      tail_hit  ? tail_idx : rd_ptr;
`else
    assign in_ready = !full;
    assign alloc    = accept;
    assign widx     = wr_ptr;
`endif

    // Scan oldest to youngest so the last match written wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        f_idx    = rd_ptr;
        if (fwd_addr != '0) begin
            if (wr_en && wr_addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                f_idx = rd_ptr + PW'(i);
                if (CW'(i) < count && addr_q[f_idx] == fwd_addr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[f_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (alloc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
            wr_en <= pop;
            if (pop) begin
                wr_addr <= addr_q[rd_ptr];
                wr_data <= data_q[rd_ptr];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count/rd_ptr.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[widx] <= in_addr;
            data_q[widx] <= in_data;
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed and random stimulus for wb_write_queue,
// checked against a queue-based model of pending writebacks.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_hold;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_hold  (wr_hold),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    logic        cur_v;
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    logic        cur_h;
    logic        cur_rdy;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic model_ready(input logic [4:0] a);
        logic r;
        r = (q.size() < DEPTH);
`ifdef WBQ_COALESCE_EN
        if (a != 0) begin
            for (int i = 1; i < q.size(); i++) begin
                if (q[i].a == a) r = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    // Drive inputs, then compare every output against the model at negedge.
    task automatic cyc_check(input logic v, input logic [4:0] a,
                             input logic [31:0] d, input logic h,
                             input logic [4:0] fa);
        logic        e_hit;
        logic [31:0] e_data;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wr_hold  = h;
        fwd_addr = fa;
        cur_v = v;
        cur_a = a;
        cur_d = d;
        cur_h = h;
        @(negedge clk);
        cur_rdy = model_ready(a);
        e_hit   = 1'b0;
        e_data  = '0;
        if (fa != 0) begin
            if (m_en && m_addr == fa) begin
                e_hit  = 1'b1;
                e_data = m_data;
            end
            foreach (q[i]) begin
                if (q[i].a == fa) begin
                    e_hit  = 1'b1;
                    e_data = q[i].d;
                end
            end
        end
        chk("count",    64'(count),    64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(cur_rdy));
        chk("wr_en",    64'(wr_en),    64'(m_en));
        chk("wr_addr",  64'(wr_addr),  64'(m_addr));
        chk("wr_data",  64'(wr_data),  64'(m_data));
        chk("fwd_hit",  64'(fwd_hit),  64'(e_hit));
        chk("fwd_data", 64'(fwd_data), 64'(e_data));
    endtask

    task automatic cyc_commit();
        logic pop;
        logic acc;
        bit   merged;
        @(posedge clk);
        pop = (q.size() > 0) && !cur_h;
        acc = cur_v && cur_rdy && (cur_a != 0);
        if (pop) begin
            m_en   = 1'b1;
            m_addr = q[0].a;
            m_data = q[0].d;
            void'(q.pop_front());
        end else begin
            m_en = 1'b0;
        end
        if (acc) begin
            merged = 1'b0;
`ifdef WBQ_COALESCE_EN
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!merged && q[i].a == cur_a) begin
                    q[i].d = cur_d;
                    merged = 1'b1;
                end
            end
`endif
            if (!merged) q.push_back('{a: cur_a, d: cur_d});
        end
        #1;
    endtask

    task automatic cyc(input logic v, input logic [4:0] a,
                       input logic [31:0] d, input logic h,
                       input logic [4:0] fa);
        cyc_check(v, a, d, h, fa);
        cyc_commit();
    endtask

    task automatic reset_mid(input logic [4:0] fa);
        in_valid = 1'b0;
        fwd_addr = fa;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count",   64'(count),    64'd0);
        chk("rst_wr_en",   64'(wr_en),    64'd0);
        chk("rst_ready",   64'(in_ready), 64'd1);
        chk("rst_fwd_hit", 64'(fwd_hit),  64'd0);
        chk("rst_wr_addr", 64'(wr_addr),  64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic        r_v;
    logic        r_h;
    logic [4:0]  r_a;
    logic [4:0]  r_fa;
    logic [31:0] r_d;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wr_hold  = 1'b0;
        fwd_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        cyc(0, 0, 0, 0, 3);

        // Single push drains one cycle after acceptance.
        cyc(1, 3, 32'h11, 0, 3);
        cyc(0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 3);

        // Fill under hold, then drain in order.
        for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'(i * 16), 1, 2);
        cyc(1, 9, 32'h99, 1, 4);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);

        // Youngest pending value wins the bypass.
        cyc(1, 5, 32'hA, 1, 5);
        cyc(1, 5, 32'hB, 1, 5);
        cyc_check(0, 0, 0, 1, 5);
        chk("byp_hit",  64'(fwd_hit),  64'd1);
        chk("byp_data", 64'(fwd_data), 64'hB);
`ifdef WBQ_COALESCE_EN
        chk("byp_count", 64'(count), 64'd1);
`else
        chk("byp_count", 64'(count), 64'd2);
`endif
        cyc_commit();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 5);

        // Address zero is accepted but dropped.
        cyc(1, 0, 32'hFFFF, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset with three entries pending.
        for (int i = 0; i < 3; i++) cyc(1, 5'(6 + i), 32'(100 + i), 1, 7);
        reset_mid(7);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 7);

        // Streaming pushes wrap the pointers.
        for (int i = 0; i < 10; i++) cyc(1, 5'(1 + i), 32'(i + 'h200), 0, 5'(i));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        // Random traffic with frequent address collisions.
        for (int n = 0; n < 400; n++) begin
            r_v  = ($urandom_range(0, 3) != 0);
            r_a  = 5'($urandom_range(0, 7));
            r_d  = $urandom;
            r_h  = ($urandom_range(0, 2) == 0);
            r_fa = 5'($urandom_range(0, 7));
            cyc(r_v, r_a, r_d, r_h, r_fa);
            if (n == 200) reset_mid(r_fa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
